// File: rtl/cdb_writeback_arbiter.sv
// rtl/cdb_writeback_arbiter.sv - three per-source completion FIFOs feeding two registered CDB ports
// Rotating-priority arbiter grants up to two FIFO heads per cycle; flush discards everything queued.
module cdb_writeback_arbiter #(
  parameter int DATA_LEN = 32,
  parameter int RRF_SEL  = 6,
  parameter int DEPTH    = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  flush_i,
  input  logic [2:0]            src_valid_i,
  input  logic [3*DATA_LEN-1:0] src_data_i,
  input  logic [3*RRF_SEL-1:0]  src_tag_i,
  input  logic [2:0]            src_rrf_we_i,
  output logic [2:0]            src_ready_o,
  output logic                  cdb0_valid_o,
  output logic                  cdb1_valid_o,
  output logic                  cdb0_rrf_we_o,
  output logic                  cdb1_rrf_we_o,
  output logic [RRF_SEL-1:0]    cdb0_tag_o,
  output logic [RRF_SEL-1:0]    cdb1_tag_o,
  output logic [DATA_LEN-1:0]   cdb0_data_o,
  output logic [DATA_LEN-1:0]   cdb1_data_o,
  output logic                  overflow_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = DATA_LEN + RRF_SEL + 1;

  logic [EW-1:0]       mem_q [3][DEPTH];
  logic [EW-1:0]       mem_d [3][DEPTH];
  logic [PW-1:0]       wptr_q [3];
  logic [PW-1:0]       wptr_d [3];
  logic [PW-1:0]       rptr_q [3];
  logic [PW-1:0]       rptr_d [3];
  logic [CW-1:0]       cnt_q [3];
  logic [CW-1:0]       cnt_d [3];
  logic [1:0]          rr_q, rr_d;
  logic                overflow_q, overflow_d;
  logic                vld_q [2];
  logic                vld_d [2];
  logic                we_q [2];
  logic                we_d [2];
  logic [RRF_SEL-1:0]  tag_q [2];
  logic [RRF_SEL-1:0]  tag_d [2];
  logic [DATA_LEN-1:0] data_q [2];
  logic [DATA_LEN-1:0] data_d [2];

  logic [2:0]          nonempty;
  logic [EW-1:0]       head [3];
  logic [1:0]          gnt_valid;
  logic [1:0]          gnt_src [2];
  logic [2:0]          push, pop;
  logic [1:0]          last_src;

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      nonempty[s]    = (cnt_q[s] != '0);
      src_ready_o[s] = (cnt_q[s] != CW'(DEPTH));
      head[s]        = mem_q[s][rptr_q[s]];
    end
  end

  // Scan rr, rr+1, rr+2 (mod 3); first two non-empty heads win ports 0 and 1.
  always_comb begin
    logic [2:0] sum;
    logic [1:0] s;
    sum        = '0;
    s          = '0;
    gnt_valid  = '0;
    gnt_src[0] = 2'd0;
    gnt_src[1] = 2'd0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, rr_q} + 3'(k);
      s   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (nonempty[s]) begin
        if (!gnt_valid[0]) begin
          gnt_valid[0] = 1'b1;
          gnt_src[0]   = s;
        end else if (!gnt_valid[1]) begin
          gnt_valid[1] = 1'b1;
          gnt_src[1]   = s;
        end
      end
    end
  end

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    push       = '0;
    pop        = '0;
    overflow_d = overflow_q | (~flush_i & |(src_valid_i & ~src_ready_o));
    last_src   = gnt_valid[1] ? gnt_src[1] : gnt_src[0];
    rr_d       = rr_q;
    if (flush_i) begin
      rr_d = 2'd0;
    end else if (gnt_valid[0]) begin
      rr_d = (last_src == 2'd2) ? 2'd0 : last_src + 2'd1;
    end
    for (int s = 0; s < 3; s++) begin
      push[s] = src_valid_i[s] & src_ready_o[s] & ~flush_i;
      pop[s]  = ((gnt_valid[0] && gnt_src[0] == 2'(s)) ||
                 (gnt_valid[1] && gnt_src[1] == 2'(s))) & ~flush_i;
      if (flush_i) begin
        cnt_d[s]  = '0;
        wptr_d[s] = '0;
        rptr_d[s] = '0;
      end else begin
        if (push[s]) begin
          mem_d[s][wptr_q[s]] = {src_rrf_we_i[s], src_tag_i[s*RRF_SEL +: RRF_SEL],
                                 src_data_i[s*DATA_LEN +: DATA_LEN]};
          wptr_d[s] = wptr_q[s] + PW'(1);
        end
        if (pop[s]) begin
          rptr_d[s] = rptr_q[s] + PW'(1);
        end
        cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      end
    end
    // Tag/data hold on an idle port; only valid and rrf_we are forced low.
    for (int p = 0; p < 2; p++) begin
      vld_d[p]  = gnt_valid[p] & ~flush_i;
      we_d[p]   = vld_d[p] & head[gnt_src[p]][EW-1];
      tag_d[p]  = tag_q[p];
      data_d[p] = data_q[p];
      if (vld_d[p]) begin
        tag_d[p]  = head[gnt_src[p]][DATA_LEN +: RRF_SEL];
        data_d[p] = head[gnt_src[p]][DATA_LEN-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int s = 0; s < 3; s++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[s][e] <= '0;
        end
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      for (int p = 0; p < 2; p++) begin
        vld_q[p]  <= 1'b0;
        we_q[p]   <= 1'b0;
        tag_q[p]  <= '0;
        data_q[p] <= '0;
      end
      rr_q       <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      we_q       <= we_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
    end
  end

  assign cdb0_valid_o  = vld_q[0];
  assign cdb1_valid_o  = vld_q[1];
  assign cdb0_rrf_we_o = we_q[0];
  assign cdb1_rrf_we_o = we_q[1];
  assign cdb0_tag_o    = tag_q[0];
  assign cdb1_tag_o    = tag_q[1];
  assign cdb0_data_o   = data_q[0];
  assign cdb1_data_o   = data_q[1];
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// tb/tb_cdb_writeback_arbiter.sv - directed self-checking bench for cdb_writeback_arbiter
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_cdb_writeback_arbiter;
  logic        clk_i;
  logic        reset_n_i;
  logic        flush_i;
  logic [2:0]  src_valid;
  logic [95:0] src_data;
  logic [17:0] src_tag;
  logic [2:0]  src_we;
  logic [2:0]  src_ready_o;
  logic        cdb0_valid_o, cdb1_valid_o, cdb0_rrf_we_o, cdb1_rrf_we_o;
  logic [5:0]  cdb0_tag_o, cdb1_tag_o;
  logic [31:0] cdb0_data_o, cdb1_data_o;
  logic        overflow_o;

  int checks;
  int errors;
  int seq [3];
  int exp_seq [3];
  int gcount [3];

  cdb_writeback_arbiter dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .flush_i      (flush_i),
    .src_valid_i  (src_valid),
    .src_data_i   (src_data),
    .src_tag_i    (src_tag),
    .src_rrf_we_i (src_we),
    .src_ready_o  (src_ready_o),
    .cdb0_valid_o (cdb0_valid_o),
    .cdb1_valid_o (cdb1_valid_o),
    .cdb0_rrf_we_o(cdb0_rrf_we_o),
    .cdb1_rrf_we_o(cdb1_rrf_we_o),
    .cdb0_tag_o   (cdb0_tag_o),
    .cdb1_tag_o   (cdb1_tag_o),
    .cdb0_data_o  (cdb0_data_o),
    .cdb1_data_o  (cdb1_data_o),
    .overflow_o   (overflow_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_cdb(input string nm, input int p, input logic v, input logic [5:0] t,
                         input logic [31:0] d, input logic we);
    check({nm, "_valid"}, (p == 0) ? cdb0_valid_o : cdb1_valid_o, v);
    if (v) begin
      check({nm, "_tag"}, (p == 0) ? cdb0_tag_o : cdb1_tag_o, t);
      check({nm, "_data"}, (p == 0) ? cdb0_data_o : cdb1_data_o, d);
      check({nm, "_rrf_we"}, (p == 0) ? cdb0_rrf_we_o : cdb1_rrf_we_o, we);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    check({nm, "_outs"}, {cdb0_valid_o, cdb1_valid_o, cdb0_rrf_we_o, cdb1_rrf_we_o,
                          cdb0_tag_o, cdb1_tag_o, cdb0_data_o, cdb1_data_o, overflow_o}, '0);
    check({nm, "_ready"}, src_ready_o, 3'b111);
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle;
    src_valid = '0;
  endtask

  task automatic put(input int s, input logic [31:0] d, input logic [5:0] t, input logic we);
    src_valid[s]         = 1'b1;
    src_data[s*32 +: 32] = d;
    src_tag[s*6 +: 6]    = t;
    src_we[s]            = we;
  endtask

  task automatic flush_pulse;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  initial begin
    logic        v;
    logic [5:0]  tg;
    logic [31:0] dt;
    checks    = 0;
    errors    = 0;
    reset_n_i = 1'b0;
    flush_i   = 1'b0;
    src_valid = '0;
    src_data  = '0;
    src_tag   = '0;
    src_we    = '0;
    for (int s = 0; s < 3; s++) begin
      seq[s] = 0; exp_seq[s] = 0; gcount[s] = 0;
    end
    #2;
    chk_all_zero("reset_init");
    #20 reset_n_i = 1'b1;
    step();

    // single ALU result, two-cycle latency
    put(0, 32'h1234, 6'd5, 1'b1);
    step(); idle();
    check("single_t1_valid", cdb0_valid_o, 1'b0);
    step();
    chk_cdb("single_p0", 0, 1'b1, 6'd5, 32'h1234, 1'b1);
    check("single_p1_valid", cdb1_valid_o, 1'b0);
    step();
    check("single_t3_valid", cdb0_valid_o, 1'b0);
    flush_pulse();

    // three simultaneous pushes, rr = 0
    put(0, 32'hAAAA0001, 6'd1, 1'b1);
    put(1, 32'hBBBB0001, 6'd2, 1'b0);
    put(2, 32'hCCCC0001, 6'd3, 1'b1);
    step(); idle();
    step();
    chk_cdb("tri_t2_p0", 0, 1'b1, 6'd1, 32'hAAAA0001, 1'b1);
    chk_cdb("tri_t2_p1", 1, 1'b1, 6'd2, 32'hBBBB0001, 1'b0);
    step();
    chk_cdb("tri_t3_p0", 0, 1'b1, 6'd3, 32'hCCCC0001, 1'b1);
    check("tri_t3_p1_valid", cdb1_valid_o, 1'b0);
    step();
    check("tri_t4_valid", {cdb0_valid_o, cdb1_valid_o}, 2'b00);
    put(0, 32'hAAAA0002, 6'd4, 1'b0);
    put(1, 32'hBBBB0002, 6'd6, 1'b1);
    put(2, 32'hCCCC0002, 6'd7, 1'b0);
    step(); idle();
    step();
    chk_cdb("rr0_p0", 0, 1'b1, 6'd4, 32'hAAAA0002, 1'b0);
    chk_cdb("rr0_p1", 1, 1'b1, 6'd6, 32'hBBBB0002, 1'b1);
    step();
    chk_cdb("rr0_t3_p0", 0, 1'b1, 6'd7, 32'hCCCC0002, 1'b0);
    step();

    // saturation of MemAccess, rr = 0, all empty
    put(0, 32'hA001, 6'd9, 1'b1); put(1, 32'hB001, 6'd17, 1'b0); put(2, 32'hC001, 6'd25, 1'b1);
    step();
    check("sat_t1_ready2", src_ready_o[2], 1'b1);
    put(0, 32'hA002, 6'd10, 1'b1); put(1, 32'hB002, 6'd18, 1'b0); put(2, 32'hC002, 6'd26, 1'b1);
    step();
    check("sat_t2_ready2", src_ready_o[2], 1'b0);
    check("sat_t2_ovf", overflow_o, 1'b0);
    chk_cdb("sat_t2_p0", 0, 1'b1, 6'd9, 32'hA001, 1'b1);
    chk_cdb("sat_t2_p1", 1, 1'b1, 6'd17, 32'hB001, 1'b0);
    put(0, 32'hA003, 6'd11, 1'b1); put(1, 32'hB003, 6'd19, 1'b0); put(2, 32'hC003, 6'd27, 1'b1);
    step(); idle();
    check("sat_t3_ovf", overflow_o, 1'b1);
    chk_cdb("sat_t3_p0", 0, 1'b1, 6'd25, 32'hC001, 1'b1);
    chk_cdb("sat_t3_p1", 1, 1'b1, 6'd10, 32'hA002, 1'b1);
    step();
    chk_cdb("sat_t4_p0", 0, 1'b1, 6'd18, 32'hB002, 1'b0);
    chk_cdb("sat_t4_p1", 1, 1'b1, 6'd26, 32'hC002, 1'b1);
    step();
    chk_cdb("sat_t5_p0", 0, 1'b1, 6'd11, 32'hA003, 1'b1);
    chk_cdb("sat_t5_p1", 1, 1'b1, 6'd19, 32'hB003, 1'b0);
    step();
    check("sat_t6_valid", {cdb0_valid_o, cdb1_valid_o}, 2'b00);
    check("sat_t6_ready", src_ready_o, 3'b111);

    // flush with entries queued
    put(0, 32'hE001, 6'd1, 1'b1); put(1, 32'hE002, 6'd2, 1'b1); put(2, 32'hE003, 6'd3, 1'b1);
    step();
    put(0, 32'hE011, 6'd1, 1'b1); put(1, 32'hE012, 6'd2, 1'b1); put(2, 32'hE013, 6'd3, 1'b1);
    step(); idle();
    flush_i = 1'b1;
    check("flush_t_valid", cdb0_valid_o, 1'b1);
    step();
    flush_i = 1'b0;
    check("flush_t1_valid", {cdb0_valid_o, cdb1_valid_o}, 2'b00);
    check("flush_t1_we", {cdb0_rrf_we_o, cdb1_rrf_we_o}, 2'b00);
    check("flush_t1_ready", src_ready_o, 3'b111);
    check("flush_t1_ovf", overflow_o, 1'b1);
    put(0, 32'hD00D, 6'd7, 1'b1);
    step(); idle();
    check("flush_t2_valid", {cdb0_valid_o, cdb1_valid_o}, 2'b00);
    step();
    chk_cdb("flush_t3_p0", 0, 1'b1, 6'd7, 32'hD00D, 1'b1);
    check("flush_t3_p1_valid", cdb1_valid_o, 1'b0);
    flush_pulse();

    // fairness and FIFO order across pointer wrap
    for (int c = 0; c <= 40; c++) begin
      for (int p = 0; p < 2; p++) begin
        v  = (p == 0) ? cdb0_valid_o : cdb1_valid_o;
        tg = (p == 0) ? cdb0_tag_o : cdb1_tag_o;
        dt = (p == 0) ? cdb0_data_o : cdb1_data_o;
        if (v) begin
          if (tg < 6'd3) begin
            check("fifo_order", dt, {4'(tg), 28'(exp_seq[tg])});
            exp_seq[tg]++;
            if (c >= 2 && c <= 31) gcount[tg]++;
          end else begin
            check("fair_tag_range", tg, 6'd0);
          end
        end
      end
      idle();
      if (c <= 29) begin
        for (int s = 0; s < 3; s++) begin
          if (src_ready_o[s]) begin
            put(s, {4'(s), 28'(seq[s])}, 6'(s), 1'b1);
            seq[s]++;
          end
        end
      end
      step();
    end
    for (int s = 0; s < 3; s++) begin
      check("fair_grants", gcount[s], 20);
      check("fair_drained", exp_seq[s], seq[s]);
    end

    // asynchronous reset mid-traffic
    put(0, 32'hF001, 6'd1, 1'b1); put(1, 32'hF002, 6'd2, 1'b1); put(2, 32'hF003, 6'd3, 1'b1);
    step();
    put(0, 32'hF011, 6'd1, 1'b1); put(1, 32'hF012, 6'd2, 1'b1); put(2, 32'hF013, 6'd3, 1'b1);
    step();
    check("prereset_valid", cdb0_valid_o, 1'b1);
    #3 reset_n_i = 1'b0;
    #1;
    chk_all_zero("reset_mid");
    idle();
    step();
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("postreset_valid", {cdb0_valid_o, cdb1_valid_o}, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
